// File: rtl/membus_ram_responder.sv
// Word-addressed synchronous RAM responder for the memory bus: one request in flight, one rvalid pulse each.
// Optional feature macro: MEMBUS_RAM_BOUNDS_EN (range check, ERR_DATA/err response, suppressed writes).
module membus_ram_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA  = DATA_WIDTH'(32'hDEAD_BEEF)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_valid_i,
    output logic                    bus_ready_o,
    input  logic [ADDR_WIDTH-1:0]   bus_addr_i,
    input  logic                    bus_wen_i,
    input  logic [DATA_WIDTH-1:0]   bus_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] bus_wmask_i,
    output logic                    bus_rvalid_o,
    output logic [DATA_WIDTH-1:0]   bus_rdata_o,
    output logic                    err_o
);

    localparam int unsigned BPW   = DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(BPW);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [3:0]  LAT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [3:0]              cnt_q;
    logic [3:0]              cnt_d;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    resp_err_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    fire_s;
    logic [ADDR_WIDTH-1:0]   offset_s;
    logic [IDX_W-1:0]        idx_s;
    logic                    in_range_s;
    logic                    unused_s;

    assign bus_ready_o = (state_q == ST_IDLE) && !rst;
    assign fire_s      = bus_valid_i && bus_ready_o;
    assign offset_s    = bus_addr_i - BASE_ADDR;
    assign idx_s       = offset_s[OFF_W +: IDX_W];
    // Byte-offset and above-depth address bits only matter to the range check.
    assign unused_s    = ^offset_s;

`ifdef MEMBUS_RAM_BOUNDS_EN
    localparam longint unsigned SPAN = longint'(DEPTH) * longint'(BPW);
    assign in_range_s = (bus_addr_i >= BASE_ADDR) && (64'(offset_s) < SPAN);
`else
    assign in_range_s = 1'b1;
`endif

    // State and latency counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept in IDLE, count down in BUSY, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (fire_s) begin
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = LAT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs decode the registered state; data lines are forced to zero outside RESP.
    always_comb begin
        bus_rvalid_o = 1'b0;
        bus_rdata_o  = '0;
        err_o        = 1'b0;
        case (state_q)
            ST_RESP: begin
                bus_rvalid_o = 1'b1;
                bus_rdata_o  = resp_data_q;
                err_o        = resp_err_q;
            end
            default: begin
                bus_rvalid_o = 1'b0;
                bus_rdata_o  = '0;
                err_o        = 1'b0;
            end
        endcase
    end

    // Response register captures the pre-write word (or the error pattern) at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else if (fire_s) begin
            resp_data_q <= in_range_s ? mem_q[idx_s] : ERR_DATA;
            resp_err_q  <= !in_range_s;
        end
    end

    // Storage array is deliberately not reset, so a write committed at accept survives a later reset.
    always_ff @(posedge clk) begin
        if (fire_s && bus_wen_i && in_range_s) begin
            for (int b = 0; b < BPW; b++) begin
                if (bus_wmask_i[b]) begin
                    mem_q[idx_s][b*8 +: 8] <= bus_wdata_i[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_membus_ram_responder.sv
// Directed bench for membus_ram_responder: LATENCY=2 main instance plus a LATENCY=1 instance for back-to-back timing.
module tb_membus_ram_responder;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        valid1;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic        ready1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        err1;

    int checks;
    int failures;

    membus_ram_responder #(.LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .bus_valid_i(valid), .bus_ready_o(ready), .bus_addr_i(addr), .bus_wen_i(wen),
        .bus_wdata_i(wdata), .bus_wmask_i(wmask), .bus_rvalid_o(rvalid), .bus_rdata_o(rdata),
        .err_o(err)
    );

    membus_ram_responder #(.LATENCY(1)) dut1 (
        .clk(clk), .rst(rst),
        .bus_valid_i(valid1), .bus_ready_o(ready1), .bus_addr_i(addr), .bus_wen_i(wen),
        .bus_wdata_i(wdata), .bus_wmask_i(wmask), .bus_rvalid_o(rvalid1), .bus_rdata_o(rdata1),
        .err_o(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request on the LATENCY=2 instance; lat = cycles from the cycle after the fire edge to rvalid, -1 on timeout.
    task automatic txn(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        addr  = a;
        wen   = w;
        wdata = d;
        wmask = m;
        valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            tick();
            n++;
        end
        rd  = 32'h0;
        er  = 1'b0;
        lat = -1;
        if (ready) begin
            tick();
            valid = 1'b0;
            lat = 0;
            while (!rvalid && lat < 20) begin
                tick();
                lat++;
            end
            if (rvalid) begin
                rd = rdata;
                er = err;
                tick();
            end else begin
                lat = -1;
            end
        end else begin
            valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        valid  = 1'b1;
        valid1 = 1'b0;
        addr   = 32'h0;
        wen    = 1'b0;
        wdata  = 32'h0;
        wmask  = 4'h0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (ready !== 1'b0) begin
                $display("FAIL reset_ready cyc%0d got=%b exp=0", i, ready);
                failures++;
            end
            checks++;
            if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
                $display("FAIL reset_outputs cyc%0d got rvalid=%b rdata=%h err=%b exp 0/0/0", i, rvalid, rdata, err);
                failures++;
            end
        end
        rst   = 1'b0;
        valid = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || ready1 !== 1'b1) begin
            $display("FAIL reset_release_ready got=%b/%b exp=1/1", ready, ready1);
            failures++;
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        logic er;
        int lat;
        txn(32'h10, 1'b1, 32'h1122_3344, 4'hF, rd, er, lat);
        checks++;
        if (lat !== 1) begin
            $display("FAIL wr_latency got=%0d exp=1", lat);
            failures++;
        end
        checks++;
        if (er !== 1'b0) begin
            $display("FAIL wr_err got=%b exp=0", er);
            failures++;
        end
        txn(32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat !== 1) begin
            $display("FAIL rd_latency got=%0d exp=1", lat);
            failures++;
        end
        checks++;
        if (rd !== 32'h1122_3344) begin
            $display("FAIL rd_data got=%h exp=11223344", rd);
            failures++;
        end
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0 || ready !== 1'b1) begin
            $display("FAIL idle_outputs got rvalid=%b rdata=%h err=%b ready=%b exp 0/0/0/1", rvalid, rdata, err, ready);
            failures++;
        end
    endtask

    task automatic test_masked_write();
        logic [31:0] rd;
        logic er;
        int lat;
        txn(32'h10, 1'b1, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        checks++;
        if (rd !== 32'h1122_3344) begin
            $display("FAIL mask_wr_old_data got=%h exp=11223344", rd);
            failures++;
        end
        txn(32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            $display("FAIL mask_rd_data got=%h exp=11bb33dd", rd);
            failures++;
        end
        txn(32'h10, 1'b1, 32'h0000_0000, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB_33DD || lat !== 1) begin
            $display("FAIL zero_mask_resp got=%h lat=%0d exp=11bb33dd lat=1", rd, lat);
            failures++;
        end
        txn(32'h13, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB_33DD) begin
            $display("FAIL zero_mask_unchanged_offset_rd got=%h exp=11bb33dd", rd);
            failures++;
        end
    endtask

    task automatic test_back_to_back();
        int nf;
        int nr;
        int overlap;
        int fire_k [3];
        int resp_k [3];
        addr   = 32'h20;
        wen    = 1'b0;
        wdata  = 32'h0;
        wmask  = 4'h0;
        valid1 = 1'b1;
        nf = 0;
        nr = 0;
        overlap = 0;
        for (int k = 0; k < 10; k++) begin
            if (nf >= 3) valid1 = 1'b0;
            if (ready1 && rvalid1) overlap++;
            if (rvalid1) begin
                if (nr < 3) resp_k[nr] = k;
                nr++;
            end
            if (valid1 && ready1) begin
                if (nf < 3) fire_k[nf] = k;
                nf++;
            end
            tick();
        end
        valid1 = 1'b0;
        checks++;
        if (nf !== 3 || nr !== 3) begin
            $display("FAIL b2b_counts got fires=%0d rvalids=%0d exp 3/3", nf, nr);
            failures++;
        end else begin
            checks++;
            if (fire_k[0] !== 0 || fire_k[1] !== 2 || fire_k[2] !== 4) begin
                $display("FAIL b2b_fire_spacing got=%0d,%0d,%0d exp=0,2,4", fire_k[0], fire_k[1], fire_k[2]);
                failures++;
            end
            checks++;
            if (resp_k[0] !== 1 || resp_k[1] !== 3 || resp_k[2] !== 5) begin
                $display("FAIL b2b_rvalid_cycles got=%0d,%0d,%0d exp=1,3,5", resp_k[0], resp_k[1], resp_k[2]);
                failures++;
            end
        end
        checks++;
        if (overlap !== 0) begin
            $display("FAIL b2b_ready_in_resp got=%0d exp=0", overlap);
            failures++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic er;
        int lat;
        int seen;
        addr  = 32'h10;
        wen   = 1'b1;
        wdata = 32'h5566_7788;
        wmask = 4'hF;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        rst   = 1'b1;
        seen  = 0;
        tick();
        if (rvalid) seen++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (rvalid) seen++;
            tick();
        end
        checks++;
        if (seen !== 0) begin
            $display("FAIL rst_mid_no_rvalid got=%0d pulses exp=0", seen);
            failures++;
        end
        checks++;
        if (ready !== 1'b1) begin
            $display("FAIL rst_mid_ready got=%b exp=1", ready);
            failures++;
        end
        txn(32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h5566_7788 || lat !== 1) begin
            $display("FAIL rst_mid_committed got=%h lat=%0d exp=55667788 lat=1", rd, lat);
            failures++;
        end
    endtask

`ifdef MEMBUS_RAM_BOUNDS_EN
    task automatic test_bounds();
        logic [31:0] rd;
        logic er;
        int lat;
        txn(32'h0, 1'b1, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        txn(32'h1000, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'hDEAD_BEEF || lat !== 1) begin
            $display("FAIL oor_write_resp got err=%b rdata=%h lat=%0d exp 1/deadbeef/1", er, rd, lat);
            failures++;
        end
        txn(32'h1000, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'hDEAD_BEEF) begin
            $display("FAIL oor_read_resp got err=%b rdata=%h exp 1/deadbeef", er, rd);
            failures++;
        end
        txn(32'h0, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
            $display("FAIL oor_no_alias got err=%b rdata=%h exp 0/0badf00d", er, rd);
            failures++;
        end
    endtask
`else
    task automatic test_alias();
        logic [31:0] rd;
        logic er;
        int lat;
        txn(32'h1010, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h5566_7788 || er !== 1'b0) begin
            $display("FAIL alias_read got=%h err=%b exp=55667788 err=0", rd, er);
            failures++;
        end
        txn(32'h1010, 1'b1, 32'h0102_0304, 4'b1000, rd, er, lat);
        txn(32'h10, 1'b0, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0166_7788) begin
            $display("FAIL alias_write got=%h exp=01667788", rd);
            failures++;
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_masked_write();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMBUS_RAM_BOUNDS_EN
        test_bounds();
`else
        test_alias();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
